fft_reorder: RTL and testbench

FFT_REORDER -- requirements
Module: fft_reorder

---
 rtl/fft_reorder.sv | 157 +++++++++++++++
 tb/tb_fft_reorder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fft_reorder.sv
// Reorders a 32-point FFT output stream from bit-reversed to natural order using ping-pong banks.
// Define FFT_REORDER_BYPASS_EN to skip the banks and register each input sample straight to the outputs.
module fft_reorder #(
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_r,
  input  logic [DW-1:0] in_i,
  output logic          out_valid,
  output logic [DW-1:0] out_r,
  output logic [DW-1:0] out_i,
  output logic [4:0]    out_idx,
  output logic          out_last
);

  logic [4:0]    wcnt_q, wcnt_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_r_q, out_r_d, out_i_q, out_i_d;
  logic [4:0]    out_idx_q, out_idx_d;
  logic          out_last_q, out_last_d;

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

`ifdef FFT_REORDER_BYPASS_EN

  always_comb begin
    wcnt_d      = in_valid ? wcnt_q + 5'd1 : wcnt_q;
    out_valid_d = in_valid;
    out_r_d     = '0;
    out_i_d     = '0;
    out_idx_d   = '0;
    out_last_d  = 1'b0;
    if (in_valid) begin
      out_r_d    = in_r;
      out_i_d    = in_i;
      out_idx_d  = wcnt_q;
      out_last_d = (wcnt_q == 5'd31);
    end
  end

`else

  typedef enum logic {IDLE, READ} state_t;

  state_t        state_q, state_d;
  logic          wsel_q, wsel_d;
  logic [1:0]    full_q, full_d;
  logic          rbank_q, rbank_d;
  logic [4:0]    raddr_q, raddr_d;
  logic          wr_last, rd_done;
  logic [2*DW-1:0] rd_data;
  logic [2*DW-1:0] mem0 [32];
  logic [2*DW-1:0] mem1 [32];

  function automatic logic [4:0] bitrev5(input logic [4:0] a);
    logic [4:0] r;
    for (int b = 0; b < 5; b++) r[4-b] = a[b];
    return r;
  endfunction

  // Bank contents are never reset; the full flags alone decide what is valid.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      if (wsel_q) mem1[bitrev5(wcnt_q)] <= {in_r, in_i};
      else        mem0[bitrev5(wcnt_q)] <= {in_r, in_i};
    end
  end

  assign rd_data = rbank_d ? mem1[raddr_d] : mem0[raddr_d];

  always_comb begin
    wr_last = in_valid && (wcnt_q == 5'd31);
    rd_done = (state_q == READ) && (raddr_q == 5'd31);
    wcnt_d  = in_valid ? wcnt_q + 5'd1 : wcnt_q;
    wsel_d  = wsel_q ^ wr_last;
    full_d  = full_q;
    if (wr_last) full_d[wsel_q]  = 1'b1;
    if (rd_done) full_d[rbank_q] = 1'b0;
    state_d = state_q;
    rbank_d = rbank_q;
    raddr_d = raddr_q;
    case (state_q)
      IDLE: begin
        // Start on the very edge the frame completes so the first output follows immediately.
        if (wr_last) begin
          state_d = READ;
          rbank_d = wsel_q;
          raddr_d = 5'd0;
        end
      end
      READ: begin
        raddr_d = raddr_q + 5'd1;
        if (rd_done) begin
          if (wr_last)                 rbank_d = wsel_q;
          else if (full_q[!rbank_q])   rbank_d = !rbank_q;
          else                         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == READ);
    out_r_d     = '0;
    out_i_d     = '0;
    out_idx_d   = '0;
    out_last_d  = 1'b0;
    if (state_d == READ) begin
      out_r_d    = rd_data[2*DW-1:DW];
      out_i_d    = rd_data[DW-1:0];
      out_idx_d  = raddr_d;
      out_last_d = (raddr_d == 5'd31);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wsel_q  <= 1'b0;
      full_q  <= '0;
      rbank_q <= 1'b0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      wsel_q  <= wsel_d;
      full_q  <= full_d;
      rbank_q <= rbank_d;
      raddr_q <= raddr_d;
    end
  end

`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      wcnt_q      <= wcnt_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_fft_reorder.sv
// Bench for fft_reorder: frame-level model with due-cycle scoreboard plus literal output checks.
module tb_fft_reorder;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_r = '0, in_i = '0;
  logic          out_valid, out_last;
  logic [DW-1:0] out_r, out_i;
  logic [4:0]    out_idx;

  fft_reorder #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
    .out_valid(out_valid), .out_r(out_r), .out_i(out_i), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [4:0]    idx;
    logic [DW-1:0] r;
    logic [DW-1:0] i;
  } exp_t;

  int            nvec = 0, nerr = 0, cyc = 0, pos = 0;
  exp_t          exp_q[$];
  logic [DW-1:0] fr_r[32], fr_i[32];
  logic [DW-1:0] log_r[$], log_i[$];

  function automatic int bitrev5(input int v);
    int r = 0;
    for (int b = 0; b < 5; b++) if (v & (1 << b)) r |= 1 << (4 - b);
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a completed frame yields natural-order outputs due on the following consecutive cycles.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && in_valid) begin
`ifdef FFT_REORDER_BYPASS_EN
      exp_q.push_back('{cyc, 5'(pos), in_r, in_i});
`else
      fr_r[pos] = in_r;
      fr_i[pos] = in_i;
      if (pos == 31)
        for (int k = 0; k < 32; k++)
          exp_q.push_back('{cyc + k, 5'(k), fr_r[bitrev5(k)], fr_i[bitrev5(k)]});
`endif
      pos = (pos + 1) % 32;
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      check("out_valid", out_valid, 1);
      check("out_r", out_r, e.r);
      check("out_i", out_i, e.i);
      check("out_idx", out_idx, e.idx);
      check("out_last", out_last, e.idx == 5'd31);
    end else begin
      check("idle_valid", out_valid, 0);
      check("idle_zero", {out_r, out_i, out_idx, out_last}, 0);
    end
    if (out_valid) begin
      log_r.push_back(out_r);
      log_i.push_back(out_i);
    end
  end

  task automatic send(input int r, input int i);
    @(negedge clk);
    in_valid = 1'b1;
    in_r = DW'(r);
    in_i = DW'(i);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic assert_reset(input int hold);
    #1 rst_n = 1'b0;
    in_valid = 1'b0;
    pos = 0;
    exp_q.delete();
    #1 check("rst_out_valid", out_valid, 0);
    check("rst_outs", {out_r, out_i, out_idx, out_last}, 0);
    repeat (hold) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int t;
    #2 check("por_out_valid", out_valid, 0);
    check("por_outs", {out_r, out_i, out_idx, out_last}, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Single frame of bit-reversed ramp.
    log_r.delete(); log_i.delete();
    for (int w = 0; w < 32; w++) send(bitrev5(w), 100 + bitrev5(w));
    gap(1);
    drain();
    check("f1_count", log_r.size(), 32);
    for (int k = 0; k < 32 && k < log_r.size(); k++) begin
`ifdef FFT_REORDER_BYPASS_EN
      check("f1_lit_r", log_r[k], bitrev5(k));
`else
      check("f1_lit_r", log_r[k], k);
      check("f1_lit_i", log_i[k], 100 + k);
`endif
    end

    // Four back-to-back frames with offsets.
    log_r.delete(); log_i.delete();
    for (int f = 0; f < 4; f++)
      for (int w = 0; w < 32; w++) send(f * 32 + bitrev5(w), 200 + w);
    gap(1);
    drain();
    check("b2b_count", log_r.size(), 128);
`ifndef FFT_REORDER_BYPASS_EN
    for (int n = 0; n < 128 && n < log_r.size(); n++) check("b2b_lit_r", log_r[n], n);
`endif

    // Alternating valid.
    for (int w = 0; w < 32; w++) begin
      send(w * 3 + 7, 1000 - w);
      gap(1);
    end
    drain();

    // Reset mid-frame, then a clean frame.
    for (int w = 0; w < 20; w++) send(w + 50, w + 60);
    @(negedge clk);
    assert_reset(2);
    gap(4);
    for (int w = 0; w < 32; w++) send(w + 500, 7 - w);
    gap(1);
    drain();

    // Reset while reading, at out_idx=10.
    for (int w = 0; w < 32; w++) send(w + 300, w + 400);
    gap(1);
    t = 0;
    while (!(out_valid && out_idx == 5'd10) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("wait_idx10", t < 100, 1);
    assert_reset(3);
    gap(40);
    for (int w = 0; w < 32; w++) send(-w - 1, w * w);
    gap(1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
